// File: rtl/event_trace_player.sv
// event_trace_player: replays a loaded trace of timestamped events as new_input pulses for a monitor.
// Define TRACE_PLAYER_LOOP_EN to repeat the trace until abort instead of finishing with done.
module event_trace_player #(
  parameter int N_IN    = 1,
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 16,
  parameter int DELTA_W = 16,
  localparam int AW     = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [AW:0]              trace_len_i,
  input  logic                     wr_en_i,
  input  logic [AW-1:0]            wr_addr_i,
  input  logic [DELTA_W-1:0]       wr_delta_i,
  input  logic [N_IN-1:0]          wr_mask_i,
  input  logic [N_IN*DATA_W-1:0]   wr_data_i,
  input  logic                     ready_i,
  output logic [N_IN*DATA_W-1:0]   input_data_o,
  output logic [N_IN-1:0]          new_input_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [AW-1:0]            ptr_o,
  output logic [15:0]              stall_cnt_o
);
  typedef enum logic {IDLE, WAIT} state_e;
  state_e state_q, state_d;
  logic [DELTA_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0] ptr_q, ptr_d, ptr_nx;
  logic [AW:0] len_q, len_d;
  logic [15:0] stall_q, stall_d;
  logic [N_IN-1:0] new_input_q, new_input_d;
  logic [N_IN*DATA_W-1:0] data_q, data_d, issue_data;
  logic done_q, done_d, last;
  logic [DELTA_W-1:0] delta_mem [DEPTH];
  logic [N_IN-1:0] mask_mem [DEPTH];
  logic [N_IN*DATA_W-1:0] data_mem [DEPTH];

  // Trace memory has no reset so a loaded trace survives a reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && state_q == IDLE) begin
      delta_mem[wr_addr_i] <= wr_delta_i;
      mask_mem[wr_addr_i]  <= wr_mask_i;
      data_mem[wr_addr_i]  <= wr_data_i;
    end
  end

  assign ptr_nx = ptr_q + 1'b1;
  assign last   = {1'b0, ptr_q} == len_q - 1'b1;

  always_comb begin
    issue_data = '0;
    for (int k = 0; k < N_IN; k++)
      issue_data[k*DATA_W +: DATA_W] = mask_mem[ptr_q][k] ? data_mem[ptr_q][k*DATA_W +: DATA_W] : '0;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    len_d       = len_q;
    stall_d     = stall_q;
    new_input_d = '0;
    data_d      = '0;
    done_d      = 1'b0;
    if (abort_i) state_d = IDLE;
    else if (en_i) begin
      if (state_q == IDLE) begin
        if (start_i && trace_len_i != '0) begin
          state_d = WAIT;
          ptr_d   = '0;
          cnt_d   = delta_mem[0];
          stall_d = '0;
          len_d   = trace_len_i;
        end else if (start_i) done_d = 1'b1;
      end else if (cnt_q > DELTA_W'(1)) cnt_d = cnt_q - 1'b1;
      else if (!ready_i) stall_d = stall_q + 16'(stall_q != 16'hFFFF);
      else begin
        new_input_d = mask_mem[ptr_q];
        data_d      = issue_data;
        if (last) begin
`ifdef TRACE_PLAYER_LOOP_EN
          ptr_d = '0;
          cnt_d = delta_mem[0];
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          ptr_d = ptr_nx;
          cnt_d = delta_mem[ptr_nx];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      len_q       <= '0;
      stall_q     <= '0;
      new_input_q <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      len_q       <= len_d;
      stall_q     <= stall_d;
      new_input_q <= new_input_d;
      data_q      <= data_d;
      done_q      <= done_d;
    end
  end

  assign input_data_o = data_q;
  assign new_input_o  = new_input_q;
  assign busy_o       = state_q == WAIT;
  assign done_o       = done_q;
  assign ptr_o        = ptr_q;
  assign stall_cnt_o  = stall_q;
endmodule

// File: tb/tb_event_trace_player.sv
// tb_event_trace_player: directed playback vectors for event_trace_player (N_IN=2, DATA_W=16).
module tb_event_trace_player;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, start = 1'b0, abort = 1'b0, wr_en = 1'b0, ready = 1'b1;
  logic [2:0] trace_len = '0;
  logic [1:0] wr_addr = '0, wr_mask = '0, new_input, ptr;
  logic [15:0] wr_delta = '0, stall_cnt;
  logic [31:0] wr_data = '0, input_data;
  logic busy, done;
  int checks = 0, failures = 0, stray = 0, n = 0, tot = 0;

  event_trace_player #(.N_IN(2), .DATA_W(16), .DEPTH(4), .DELTA_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .start_i(start), .abort_i(abort),
    .trace_len_i(trace_len), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_delta_i(wr_delta),
    .wr_mask_i(wr_mask), .wr_data_i(wr_data), .ready_i(ready), .input_data_o(input_data),
    .new_input_o(new_input), .busy_o(busy), .done_o(done), .ptr_o(ptr), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic [1:0] m, input logic [31:0] v);
    wr_en = 1'b1; wr_addr = a; wr_delta = d; wr_mask = m; wr_data = v;
    @(posedge clk); #1 wr_en = 1'b0;
  endtask

  task automatic start_play(input logic [2:0] len);
    trace_len = len; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Counts edges until a strobe appears (bounded); flags data or done outside a pulse.
  task automatic wait_pulse(input int lim, output int cnt);
    cnt = 0;
    do begin
      @(posedge clk); #1 cnt++;
      if (new_input == '0 && (input_data != '0 || done)) stray++;
    end while (new_input == '0 && cnt < lim);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_new_input", new_input, 0);
    check("rst_data", input_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ptr", ptr, 0);
    check("rst_stall", stall_cnt, 0);
    rst_n = 1'b1;
`ifdef TRACE_PLAYER_LOOP_EN
    wr(0, 3, 2'b01, 32'd1);
    wr(1, 4, 2'b01, 32'd2);
    start_play(2);
    for (int i = 0; i < 6; i++) begin
      wait_pulse(20, n);
      check("loop_gap", n, (i % 2) ? 4 : 3);
      check("loop_data", input_data, (i % 2) ? 2 : 1);
      check("loop_ptr", ptr, (i % 2) ? 0 : 1);
      check("loop_done", done, 0);
      check("loop_busy", busy, 1);
    end
    abort = 1'b1; @(posedge clk); #1 abort = 1'b0;
    check("loop_abort_busy", busy, 0);
`else
    // Test 1: basic timing
    wr(0, 1000, 2'b01, 32'd1);
    wr(1, 300, 2'b01, 32'd2);
    wr(2, 100, 2'b01, 32'd3);
    start_play(3);
    check("t1_busy", busy, 1);
    wait_pulse(2000, n); check("t1_gap0", n, 1000); check("t1_val0", input_data, 1); check("t1_done0", done, 0);
    wait_pulse(2000, n); check("t1_gap1", n, 300); check("t1_val1", input_data, 2);
    wait_pulse(2000, n); check("t1_gap2", n, 100); check("t1_val2", input_data, 3);
    check("t1_done", done, 1); check("t1_idle", busy, 0);
    @(posedge clk); #1 check("t1_done_1cyc", done, 0); check("t1_after_data", input_data, 0);
    // Test 2: 5 stall cycles around the second issue
    start_play(3);
    wait_pulse(2000, n); check("t2_gap0", n, 1000);
    repeat (299) @(posedge clk);
    #1 ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 ready = 1'b1;
    wait_pulse(2000, n); check("t2_gap1", 304 + n, 305); check("t2_val1", input_data, 2);
    wait_pulse(2000, n); check("t2_gap2", n, 100); check("t2_stall", stall_cnt, 5); check("t2_done", done, 1);
    // Test 3: two channels, empty mask, back-to-back
    wr(0, 2, 2'b01, {16'hdead, 16'd7});
    wr(1, 1, 2'b00, 32'h5555_5555);
    wr(2, 1, 2'b11, {16'd9, 16'd8});
    start_play(3);
    wait_pulse(10, n); check("t3_gap0", n, 2); check("t3_mask0", new_input, 2'b01); check("t3_val0", input_data, 32'd7);
    @(posedge clk); #1 check("t3_mask1", new_input, 0); check("t3_val1", input_data, 0);
    @(posedge clk); #1 check("t3_mask2", new_input, 2'b11); check("t3_val2", input_data, {16'd9, 16'd8});
    check("t3_done", done, 1);
    // Test 4: write/start while busy ignored, abort, reset, empty trace
    wr(0, 50, 2'b01, {16'hdead, 16'd7});
    start_play(3);
    repeat (10) @(posedge clk);
    #1 wr(0, 5, 2'b11, 32'hffff_ffff);
    start_play(2);
    abort = 1'b1; @(posedge clk); #1 abort = 1'b0;
    check("t4_abort_busy", busy, 0); check("t4_abort_done", done, 0); check("t4_abort_ptr", ptr, 0);
    wait_pulse(100, n); check("t4_abort_quiet", n, 100); check("t4_abort_mask", new_input, 0);
    start_play(3);
    wait_pulse(200, n); check("t4_wr_dropped_gap", n, 50); check("t4_wr_dropped_val", input_data, 32'd7);
    wait_pulse(10, n); check("t4_last_gap", n, 2); check("t4_last_done", done, 1);
    start_play(3);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("t4_rst_busy", busy, 0); check("t4_rst_ptr", ptr, 0);
    @(negedge clk) rst_n = 1'b1;
    wait_pulse(100, n); check("t4_rst_quiet", n, 100); check("t4_rst_done", done, 0);
    start_play(0);
    check("t4_len0_done", done, 1); check("t4_len0_busy", busy, 0);
    @(posedge clk); #1 check("t4_len0_done_1cyc", done, 0);
    // Test 5: en=0 for 10 cycles mid-delay
    start_play(3);
    repeat (20) @(posedge clk);
    #1 en = 1'b0;
    wait_pulse(10, n); check("t5_frozen", n, 10); check("t5_frozen_mask", new_input, 0);
    #0 en = 1'b1;
    wait_pulse(200, tot); check("t5_shift", 30 + tot, 60); check("t5_val", input_data, 32'd7);
    wait_pulse(10, n); check("t5_last", n, 2); check("t5_done", done, 1);
`endif
    check("no_stray_output", stray, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
